// File: rtl/ascii_to_binary_if.sv
// ascii_to_binary_if: character handshake in, parsed value and status pulses out
interface ascii_to_binary_if #(parameter int NIBBLE_SIZE = 3);
  localparam int W = 4 * NIBBLE_SIZE;
  logic         enable;
  logic         asciiValid;
  logic [7:0]   asciiChar;
  logic         asciiReady;
  logic [W-1:0] binaryOutput;
  logic         binaryValid;
  logic         parseError;
  modport master (output enable, asciiValid, asciiChar, input asciiReady, binaryOutput, binaryValid, parseError);
  modport slave  (input enable, asciiValid, asciiChar, output asciiReady, binaryOutput, binaryValid, parseError);
endinterface

// File: rtl/ascii_to_binary.sv
// ascii_to_binary: parses terminated decimal ASCII numbers into W-bit values; define ASCII_TO_BINARY_SIGN_EN for signed '-' input
module ascii_to_binary #(parameter int NIBBLE_SIZE = 3) (
  input logic clk,
  input logic reset,
  ascii_to_binary_if.slave bus
);
  localparam int W = 4 * NIBBLE_SIZE;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [W+3:0] acc_q, acc_d, mac, lim;
  logic [W-1:0] out_q, out_d, res;
  logic bv_q, pe_q, is_dig, is_term, is_minus, empty, take;
  assign is_dig = bus.asciiChar inside {[8'h30:8'h39]};
  assign is_term = bus.asciiChar inside {8'h0D, 8'h0A, 8'h20};
  assign bus.asciiReady = bus.enable && !reset && state_q != DONE;
  assign take = bus.asciiValid && bus.asciiReady;
  assign mac = acc_q * (W+4)'(10) + (W+4)'(bus.asciiChar[3:0]);
  assign bus.binaryOutput = out_q;
  assign bus.binaryValid = bv_q;
  assign bus.parseError = pe_q;
`ifdef ASCII_TO_BINARY_SIGN_EN
  logic neg_q, neg_d, seen_q, seen_d;
  assign is_minus = bus.asciiChar == 8'h2D;
  assign empty = !seen_q;
  assign lim = ((W+4)'(1) << (W-1)) - (W+4)'(!neg_q);
  assign res = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  // sign flag and digit-seen flag, captured at the start of each number
  always_comb begin
    neg_d = neg_q;
    seen_d = seen_q;
    if (bus.enable && take && state_q == IDLE) begin
      neg_d = is_minus;
      seen_d = is_dig;
    end else if (bus.enable && take && state_q == ACCUM && is_dig) seen_d = 1'b1;
  end
  // sign state registers
  always_ff @(posedge clk or posedge reset)
    if (reset) {neg_q, seen_q} <= 2'b00;
    else {neg_q, seen_q} <= {neg_d, seen_d};
`else
  assign is_minus = 1'b0;
  assign empty = 1'b0;
  assign lim = (W+4)'({W{1'b1}});
  assign res = acc_q[W-1:0];
`endif
  // next-state, accumulator and result selection
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    out_d = out_q;
    if (bus.enable)
      case (state_q)
        IDLE:
          if (take && is_dig) begin
            acc_d = (W+4)'(bus.asciiChar[3:0]);
            state_d = ACCUM;
          end else if (take && is_minus) begin
            acc_d = '0;
            state_d = ACCUM;
          end else if (take && !is_term) state_d = ERROR;
        ACCUM:
          if (take && is_dig) begin
            acc_d = mac;
            state_d = mac > lim ? ERROR : ACCUM;
          end else if (take && is_term) begin
            state_d = empty ? ERROR : DONE;
            out_d = empty ? out_q : res;
          end else if (take) state_d = ERROR;
        DONE: state_d = IDLE;
        default: state_d = take && is_term ? IDLE : ERROR;
      endcase
  end
  // state, accumulator, result and entry-pulse registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      out_q <= '0;
      bv_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      out_q <= out_d;
      bv_q <= state_d == DONE && state_q != DONE;
      pe_q <= state_d == ERROR && state_q != ERROR;
    end
endmodule

// File: tb/tb_ascii_to_binary.sv
// tb_ascii_to_binary: token-level scoreboard bench for ascii_to_binary
module tb_ascii_to_binary;
  typedef logic [7:0] ch_t;
  typedef struct {bit err; int val;} ev_t;
  logic clk = 0, reset = 1;
  int checks = 0, errors = 0, exp_out = 0;
  bit gaps = 0, rand_en = 0;
  ev_t exp_q[$];
  ev_t e;
  ascii_to_binary_if #(.NIBBLE_SIZE(3)) bus();
  ascii_to_binary #(.NIBBLE_SIZE(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic void eval(input ch_t t[$], output bit ok, output int v);
    int i = 0;
    bit neg = 0;
    longint m = 0, lim;
    lim = 4095;
`ifdef ASCII_TO_BINARY_SIGN_EN
    if (t[0] == 8'h2D) begin neg = 1; i = 1; end
    lim = neg ? 2048 : 2047;
`endif
    ok = t.size() > i;
    for (int k = i; k < t.size(); k++)
      if (t[k] >= 8'h30 && t[k] <= 8'h39) m = (m * 10 + t[k] - 48 > 100000) ? 100000 : m * 10 + t[k] - 48;
      else ok = 0;
    ok = ok && m <= lim;
    v = neg ? int'((-m) & 4095) : int'(m);
  endfunction

  function automatic bit is_t(input ch_t c);
    return c == 8'h0D || c == 8'h0A || c == 8'h20;
  endfunction

  function automatic ch_t term();
    int r = $urandom_range(0, 2);
    return r == 0 ? 8'h0D : r == 1 ? 8'h0A : 8'h20;
  endfunction

  function automatic ch_t bad();
    ch_t b = ch_t'($urandom_range(0, 255));
    return (is_t(b) || (b >= 8'h30 && b <= 8'h39)) ? 8'h41 : b;
  endfunction

  task automatic send(input ch_t c);
    int n = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.asciiValid = 0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.asciiValid = 1;
    bus.asciiChar = c;
    do begin @(negedge clk); n++; end while (!bus.asciiReady && n < 500);
    if (!bus.asciiReady) begin
      checks++; errors++;
      $display("FAIL accept_timeout char=%02h ready=%0b required=1", c, bus.asciiReady);
    end
    @(posedge clk);
    #1 bus.asciiValid = 0;
  endtask

  task automatic run(input ch_t s[$]);
    ch_t t[$];
    bit ok;
    int v;
    foreach (s[i])
      if (is_t(s[i])) begin
        if (t.size() > 0) begin
          eval(t, ok, v);
          exp_q.push_back('{!ok, v});
        end
        t = {};
      end else t.push_back(s[i]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic run_s(input string s);
    ch_t b[$];
    foreach (s[i]) b.push_back(ch_t'(s[i]));
    run(b);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
  endtask

  // monitor: pop expected event on every output pulse
  always @(negedge clk)
    if (!reset && (bus.binaryValid || bus.parseError)) begin
      checks++;
      if (bus.binaryValid && bus.parseError) begin
        errors++;
        $display("FAIL both_pulses valid=1 error=1 required=one_hot");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse valid=%0b error=%0b required=none", bus.binaryValid, bus.parseError);
      end else begin
        e = exp_q.pop_front();
        if (e.err != bus.parseError) begin
          errors++;
          $display("FAIL pulse_kind error=%0b required=%0b (val %0h)", bus.parseError, e.err, e.val);
        end else if (!e.err && (bus.binaryOutput != 12'(e.val) || bus.asciiReady)) begin
          errors++;
          $display("FAIL value out=%0h ready=%0b required out=%0h ready=0", bus.binaryOutput, bus.asciiReady, e.val);
        end else if (e.err && bus.binaryOutput != 12'(exp_out)) begin
          errors++;
          $display("FAIL out_on_error out=%0h required=%0h", bus.binaryOutput, exp_out);
        end
        if (!e.err) exp_out = e.val;
      end
    end

  // random enable throttling
  always @(posedge clk) begin
    #1 if (rand_en) bus.enable = $urandom_range(0, 3) != 0;
  end

  initial begin
    ch_t s[$];
    bus.enable = 1;
    bus.asciiValid = 0;
    bus.asciiChar = 0;
    #1;
    chk("reset_ready", bus.asciiReady, 0);
    chk("reset_out", {bus.binaryValid, bus.parseError, bus.binaryOutput}, 0);
    repeat (3) @(posedge clk);
    #2 reset = 0;
    run_s("123\015");
    chk("valid_after_cr", {bus.binaryValid, bus.asciiReady, bus.binaryOutput}, {2'b10, 12'h07B});
    run_s("4095 ");
    run_s("4096 ");
    run_s("1a2\n7\n");
    run_s("  \015");
    run_s("0007\n");
`ifdef ASCII_TO_BINARY_SIGN_EN
    run_s("-2048\015");
    run_s("-2049\015");
    run_s("2048\015");
    run_s("-\015");
    run_s("-0\015");
`endif
    drain();
    chk("out_after_directed", bus.binaryOutput, exp_out);
    send("1");
    send("2");
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("mid_reset_ready", bus.asciiReady, 0);
    chk("mid_reset_out", {bus.binaryValid, bus.parseError, bus.binaryOutput}, 0);
    @(posedge clk);
    #2 reset = 0;
    exp_out = 0;
    run_s("5\015");
    drain();
    chk("out_after_reset", bus.binaryOutput, 5);
    gaps = 1;
    rand_en = 1;
    for (int it = 0; it < 80; it++) begin
      s = {};
      repeat ($urandom_range(0, 2)) s.push_back(term());
      if ($urandom_range(0, 4) == 0) s.push_back(8'h2D);
      repeat ($urandom_range(0, 5)) s.push_back(ch_t'(8'h30 + $urandom_range(0, 9)));
      if ($urandom_range(0, 5) == 0) s.insert($urandom_range(0, s.size()), bad());
      s.push_back(term());
      run(s);
    end
    rand_en = 0;
    @(posedge clk);
    #1 bus.enable = 1;
    drain();
    chk("final_out", bus.binaryOutput, exp_out);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
